// File: rtl/btn_ctrl.sv
// btn_ctrl: four-button debounced cursor-move controller with optional auto-repeat.
// Ports: clk (rising edge); rst (async, active-low);
//        btn_up/btn_down/btn_left/btn_right (raw async buttons, active-high);
//        fire (one-cycle move strobe); row_en/col_en (move axis); add_n (0 inc, 1 dec).
// Option: define BTN_AUTOREPEAT_EN to re-fire while a button stays held.
module btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY = 1024,
  parameter int REPEAT_PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic fire,
  output logic row_en,
  output logic col_en,
  output logic add_n
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FIRE, HOLD, RELEASE} state_t;
  state_t r_state, w_next;
  logic [3:0] w_btn, r_s1, r_s2, r_deb, r_deb_q, w_rise, w_pick, r_sel;
  logic [CW-1:0] r_cnt [4];
  logic r_fire, r_row, r_col, r_add, w_held, w_hit;
  // bit order: 0 up, 1 down, 2 left, 3 right
  assign w_btn = {btn_right, btn_left, btn_down, btn_up};
  assign w_rise = r_deb & ~r_deb_q;
  assign w_held = |(r_sel & r_deb);
  assign w_pick = w_rise[0] ? 4'b0001 : w_rise[1] ? 4'b0010 :
                  w_rise[2] ? 4'b0100 : w_rise[3] ? 4'b1000 : 4'b0000;
  assign fire = r_fire;
  assign row_en = r_row;
  assign col_en = r_col;
  assign add_n = r_add;
  // Level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_deb <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 4; i++)
        if (r_s2[i] == r_deb[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = |w_rise ? FIRE : IDLE;
      FIRE:    w_next = HOLD;
      HOLD:    w_next = w_held ? HOLD : RELEASE;
      RELEASE: w_next = |r_deb ? RELEASE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Outputs are registered, so fire trails the FIRE state by one cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_fire <= 1'b0;
      r_row <= 1'b0;
      r_col <= 1'b0;
      r_add <= 1'b0;
      r_sel <= '0;
    end else begin
      r_fire <= (r_state == FIRE) | w_hit;
      if (r_state == IDLE && |w_rise) begin
        r_sel <= w_pick;
        r_row <= w_pick[0] | w_pick[1];
        r_col <= w_pick[2] | w_pick[3];
        r_add <= w_pick[0] | w_pick[2];
      end
    end
`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX);
  logic [RW-1:0] r_rpt;
  logic r_rep;
  // r_rep selects the first (delay) or subsequent (period) interval.
  assign w_hit = r_state == HOLD && w_held &&
                 r_rpt == (r_rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rpt <= '0;
      r_rep <= 1'b0;
    end else if (r_state != HOLD || w_hit) begin
      r_rpt <= '0;
      r_rep <= r_state == HOLD;
    end else r_rpt <= r_rpt + 1'b1;
`else
  assign w_hit = 1'b0;
`endif
endmodule

// File: tb/tb_btn_ctrl.sv
// tb_btn_ctrl: scoreboard bench for btn_ctrl (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5).
module tb_btn_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic fire, row_en, col_en, add_n;
  logic prev_fire = 1'b0;
  int cyc = 0, n_pass = 0, n_total = 0;
  typedef struct {int cyc; logic row; logic col; logic add;} exp_t;
  exp_t sb[$];
  btn_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .fire(fire), .row_en(row_en), .col_en(col_en), .add_n(add_n)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Fire monitor: every strobe must match the oldest expected move.
  always @(negedge clk) begin
    exp_t e;
    if (fire) begin
      n_total++;
      if (sb.size() == 0) $display("FAIL unexpected_fire cyc=%0d got fire=1 want none", cyc);
      else begin
        e = sb.pop_front();
        if (cyc !== e.cyc) $display("FAIL fire_time got cyc=%0d want cyc=%0d", cyc, e.cyc);
        else n_pass++;
        n_total++;
        if ({row_en, col_en, add_n} !== {e.row, e.col, e.add})
          $display("FAIL fire_dir cyc=%0d got row/col/add=%b%b%b want %b%b%b",
                   cyc, row_en, col_en, add_n, e.row, e.col, e.add);
        else n_pass++;
      end
      n_total++;
      if (prev_fire) $display("FAIL fire_consecutive cyc=%0d got two-cycle fire want single", cyc);
      else n_pass++;
      n_total++;
      if (row_en && col_en) $display("FAIL axis_exclusive cyc=%0d got row_en=1 col_en=1 want one", cyc);
      else n_pass++;
    end
    prev_fire <= fire;
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_fire(input int c, input logic r, input logic co, input logic a);
    exp_t e;
    e.cyc = c; e.row = r; e.col = co; e.add = a;
    sb.push_back(e);
  endtask
  task automatic test_reset;
    tick(2);
    n_total++;
    if ({fire, row_en, col_en, add_n} !== 4'b0000)
      $display("FAIL reset_outputs got %b%b%b%b want 0000", fire, row_en, col_en, add_n);
    else n_pass++;
    rst = 1'b1;
    tick(3);
    n_total++;
    if ({fire, row_en, col_en, add_n} !== 4'b0000)
      $display("FAIL post_reset_idle got %b%b%b%b want 0000", fire, row_en, col_en, add_n);
    else n_pass++;
  endtask
  task automatic test_down;
    expect_fire(cyc + 8, 1'b1, 1'b0, 1'b0);
    btn_down = 1'b1;
    tick(10);
    btn_down = 1'b0;
    tick(20);
    n_total++;
    if (sb.size() !== 0) $display("FAIL down_missing got pending=%0d want 0", sb.size());
    else n_pass++;
    n_total++;
    if ({row_en, col_en, add_n} !== 3'b100)
      $display("FAIL down_held got %b%b%b want 100", row_en, col_en, add_n);
    else n_pass++;
  endtask
  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      btn_right = ~btn_right;
      tick(2);
    end
    btn_right = 1'b0;
    tick(15);
    n_total++;
    if (sb.size() !== 0) $display("FAIL bounce_queue got pending=%0d want 0", sb.size());
    else n_pass++;
    n_total++;
    if ({row_en, col_en, add_n} !== 3'b100)
      $display("FAIL bounce_unchanged got %b%b%b want 100", row_en, col_en, add_n);
    else n_pass++;
  endtask
  task automatic test_priority;
    expect_fire(cyc + 8, 1'b1, 1'b0, 1'b1);
    btn_up = 1'b1;
    btn_left = 1'b1;
    tick(10);
    btn_left = 1'b0;
    tick(5);
    btn_up = 1'b0;
    tick(20);
    n_total++;
    if (sb.size() !== 0) $display("FAIL priority_missing got pending=%0d want 0", sb.size());
    else n_pass++;
    n_total++;
    if ({row_en, col_en, add_n} !== 3'b101)
      $display("FAIL priority_dir got %b%b%b want 101", row_en, col_en, add_n);
    else n_pass++;
  endtask
  task automatic test_repeat;
    int t0;
    t0 = cyc + 8;
    expect_fire(t0, 1'b0, 1'b1, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) expect_fire(t0 + 20 + 5 * i, 1'b0, 1'b1, 1'b1);
`endif
    btn_left = 1'b1;
    tick(40);
    btn_left = 1'b0;
    tick(20);
    n_total++;
    if (sb.size() !== 0) $display("FAIL repeat_missing got pending=%0d want 0", sb.size());
    else n_pass++;
    n_total++;
    if ({row_en, col_en, add_n} !== 3'b011)
      $display("FAIL repeat_dir got %b%b%b want 011", row_en, col_en, add_n);
    else n_pass++;
  endtask
  task automatic test_reset_hold;
    expect_fire(cyc + 8, 1'b1, 1'b0, 1'b1);
    btn_up = 1'b1;
    tick(12);
    n_total++;
    if ({row_en, add_n} !== 2'b11) $display("FAIL hold_before_reset got row/add=%b%b want 11", row_en, add_n);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({fire, row_en, col_en, add_n} !== 4'b0000)
      $display("FAIL reset_async got %b%b%b%b want 0000", fire, row_en, col_en, add_n);
    else n_pass++;
    tick(2);
    rst = 1'b1;
    expect_fire(cyc + 8, 1'b1, 1'b0, 1'b1);
    tick(12);
    btn_up = 1'b0;
    tick(20);
    n_total++;
    if (sb.size() !== 0) $display("FAIL reset_refire got pending=%0d want 0", sb.size());
    else n_pass++;
  endtask
  initial begin
    test_reset;
    test_down;
    test_bounce;
    test_priority;
    test_repeat;
    test_reset_hold;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/btn_ctrl.md
BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to change a debounced level (>=1).
REQ-002 Parameter REPEAT_DELAY, default 1024, cycles from first fire to first auto-repeat fire (>=2).
REQ-003 Parameter REPEAT_PERIOD, default 256, cycles between auto-repeat fires (>=2).
REQ-004 Port clk  in  1  sole clock, rising edge.
REQ-005 Port rst  in  1  one clock; reset is asynchronous and active-low.
REQ-006 Ports btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous push-buttons, active-high.
REQ-007 Port fire  out  1  single-cycle move strobe to the cursor counter.
REQ-008 Port row_en  out  1  move applies to the row axis.
REQ-009 Port col_en  out  1  move applies to the column axis.
REQ-010 Port add_n  out  1  0 = increment, 1 = decrement.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a per-button debouncer with a $clog2(DEBOUNCE_CYCLES+1)-bit counter.
REQ-012 The debounced level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap clears the counter.
REQ-013 Mapping: up -> row_en=1, add_n=1; down -> row_en=1, add_n=0; left -> col_en=1, add_n=1; right -> col_en=1, add_n=0.
REQ-014 FSM states: IDLE, FIRE, HOLD, RELEASE.
REQ-015 IDLE: on any debounced rising edge, latch direction by priority up>down>left>right, go to FIRE.
REQ-016 FIRE: fire=1 for exactly one cycle, then HOLD.
REQ-017 HOLD: stay while the latched button's debounced level is 1; when it falls, go to RELEASE.
REQ-018 RELEASE: wait until all four debounced levels are 0, then IDLE.
REQ-019 Presses of other buttons during FIRE/HOLD/RELEASE SHALL be ignored (no fire).
REQ-020 row_en/col_en/add_n SHALL be valid in the fire cycle and held until the next direction latch; row_en and col_en SHALL never both be 1.
REQ-021 fire SHALL never be high on two consecutive cycles.
REQ-022 Latency: raw input first sampled high at edge k (stable) -> fire high in the cycle after edge k+3+DEBOUNCE_CYCLES.
REQ-023 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no fire.

Reset
REQ-024 rst=0 SHALL asynchronously clear synchronizers, debounce counters, debounced levels, FSM (IDLE), repeat counter, and set fire=0, row_en=0, col_en=0, add_n=0.
REQ-025 Reset mid-HOLD SHALL abort with no fire; a button held across reset release SHALL debounce and fire once as a new press.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN defined: in HOLD, fire pulses again REPEAT_DELAY cycles after the initial fire, then every REPEAT_PERIOD cycles while held; direction unchanged; repeat counter cleared on leaving HOLD.
REQ-027 Macro BTN_AUTOREPEAT_EN undefined: exactly one fire per press, no repeat counter logic present.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 Clean btn_down press held 10 cycles -> one fire, row_en=1, col_en=0, add_n=0, timing per REQ-022.
REQ-029 btn_right toggling every 2 cycles for 20 cycles, then low -> no fire, outputs unchanged.
REQ-030 btn_up and btn_left rise same cycle -> one fire, row_en=1, add_n=1; release left only, keep up -> no further fire.
REQ-031 btn_left held 40 cycles with BTN_AUTOREPEAT_EN -> fires at t0, t0+20, t0+25, t0+30, t0+35 (fire-cycle offsets); without macro -> single fire at t0.
REQ-032 rst pulsed low while in HOLD with btn_up held -> outputs 0 immediately; after release of rst, btn_up still held -> one fire per REQ-022.
